game_ram_scheduler: RTL and testbench
=====================================

// Module: game_ram_scheduler
// PURPOSE
//  Single owner of the 31x50 game character RAM write port and its free read port. Accepts three job
//  types from the game FSM (whole-RAM clear, row refresh, key search/erase), arbitrates them by fixed
//  priority and runs each as a pipelined address sweep. Reports per-job results (missed char, key hit).
// PARAMETERS
//  COLS     50  characters per row
//  ROWS     31  rows incl. off-screen spawn row
//  AW       11  RAM address width (COLS*ROWS=1550 <= 2**AW)
//  DW       8   RAM data width (ASCII; 0 = empty cell)
// PORTS
//  clk        in   1   system clock (50MHz)
//  reset      in   1   synchronous, active-high
//  clr_req    in   1   request: zero every cell (level, hold until clr_ack)
//  row_req    in   1   request: clear row row_idx, then plant row_cnt chars (level, hold until row_ack)
//  row_idx    in   5   target row, sampled at row_ack
//  row_cnt    in   3   chars to plant (0..7), sampled at row_ack
//  new_col    in   7   random column, reduced mod COLS, sampled per plant
//  new_ascii  in   DW  random char, sampled per plant
//  new_next   out  1   pulse: advance random sources (one per planted char)
//  key_req    in   1   request: find/erase key_ascii (level, hold until key_ack)
//  key_ascii  in   DW  char to search, sampled at key_ack
//  clr_ack/row_ack/key_ack out 1 each  one-cycle accept pulses
//  busy       out  1   job in progress
//  done       out  1   one-cycle completion pulse
//  done_job   out  2   job of last done: 0 CLR, 1 ROW, 2 KEY (held until next done)
//  miss       out  1   ROW: a non-zero cell was overwritten in the clear pass (held)
//  hit        out  1   KEY: at least one match erased (held)
//  ram_raddr  out  AW  read address; ram_rdata valid one cycle later
//  ram_rdata  in   DW  read data
//  ram_waddr/ram_wdata/ram_wren out AW/DW/1  write port
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, job abandoned without done; RAM contents untouched.
//  States: IDLE, CLR, ROW_CLR, ROW_NEW, KEY_SCAN, FINISH.
//  IDLE: priority clr > row > key; winner's ack pulses, args latched, busy=1 next cycle. Losers stay pending.
//  CLR: write 0 to addr 0..1549, one per cycle; 1550 cycles; then FINISH.
//  ROW_CLR: read base+c in cycle c, write 0 to base+c in c+1 (base=row_idx*COLS); miss|=(rdata!=0);
//   COLS+1 cycles. Then ROW_NEW if row_cnt>0 else FINISH.
//  ROW_NEW: row_cnt cycles; each writes new_ascii at base+(new_col%COLS), pulses new_next. Same column twice
//   -> last write wins. row_idx>=ROWS: no RAM access, done with miss=0.
//  KEY_SCAN: pipelined read 0..1549; rdata==key_ascii at addr a -> write 0 to a next cycle, hit=1, stop.
//   Exhausted -> hit=0. key_ascii==0 -> done next cycle, hit=0, no access.
//  FINISH: done=1 one cycle, busy=0, -> IDLE. Read and write never target conflicting jobs (one job at a time).
//  Counters saturate at CELLS-1; address math in AW bits, no wrap.
// CONFIGURATION
//  KEY_ERASE_ALL_EN undefined: KEY erases first match only (scan stops).
//  KEY_ERASE_ALL_EN defined: full scan, every match erased; extra output hit_cnt[AW-1:0] = matches, hit=(hit_cnt!=0).
// STRUCTURE
//  Package game_ram_pkg: COLS, ROWS, CELLS, job_t {JOB_CLR,JOB_ROW,JOB_KEY}, state enum.
//  Sub-module game_ram_sweep: loadable address counter with start/step/last flag, shared by all sweeps.
// TESTING
//  Reset held 3 cycles -> busy=0, done=0, ram_wren=0, all acks 0.
//  clr_req -> clr_ack, 1550 writes of 0 at 0..1549, done with done_job=0 exactly once.
//  RAM 'A' at 157; row_req idx=3 cnt=2 new_col=57 ascii=0x42 -> zeros 150..199, miss=1, two 0x42 writes at 157, two new_next.
//  'K' at 10 and 400; key_req 0x4B -> only 10 cleared, hit=1; with KEY_ERASE_ALL_EN both cleared, hit_cnt=2.
//  clr_req, row_req, key_req same cycle -> served CLR, ROW, KEY in order, three dones.
//  reset at CLR addr 200 -> ram_wren=0 next cycle, no done; key_ascii=0 -> done, hit=0, no writes.

Source files
------------

// File: rtl/game_ram_pkg.sv
// Shared constants, job codes and state encoding for the game character RAM scheduler.
package game_ram_pkg;

  localparam int COLS  = 50;
  localparam int ROWS  = 31;
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = 11;
  localparam int DW    = 8;

  typedef enum logic [1:0] {
    JOB_CLR = 2'd0,
    JOB_ROW = 2'd1,
    JOB_KEY = 2'd2
  } job_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_ROW_CLR,
    ST_ROW_NEW,
    ST_KEY_SCAN,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/game_ram_sweep.sv
// Loadable address counter shared by every RAM sweep; holds at the end address once reached.
module game_ram_sweep
  import game_ram_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [AW-1:0] start_i,
  input  logic [AW-1:0] end_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] end_q, end_d;

  always_comb begin
    addr_d = addr_q;
    end_d  = end_q;
    if (load_i) begin
      addr_d = start_i;
      end_d  = end_i;
    end else if (step_i && (addr_q != end_q)) begin
      addr_d = addr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      end_q  <= '0;
    end else begin
      addr_q <= addr_d;
      end_q  <= end_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (addr_q == end_q);

endmodule

// File: rtl/game_ram_scheduler.sv
// Owns the character RAM ports and runs clear / row refresh / key search jobs one at a time.
// Build option KEY_ERASE_ALL_EN: key search erases every match and reports hit_cnt.
module game_ram_scheduler
  import game_ram_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  input  logic          row_req,
  input  logic [4:0]    row_idx,
  input  logic [2:0]    row_cnt,
  input  logic [6:0]    new_col,
  input  logic [DW-1:0] new_ascii,
  output logic          new_next,
  input  logic          key_req,
  input  logic [DW-1:0] key_ascii,
  output logic          clr_ack,
  output logic          row_ack,
  output logic          key_ack,
  output logic          busy,
  output logic          done,
  output logic [1:0]    done_job,
  output logic          miss,
  output logic          hit,
`ifdef KEY_ERASE_ALL_EN
  output logic [AW-1:0] hit_cnt,
`endif
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_wren
);

  state_t        state_q, state_d;
  job_t          job_q, job_d;
  logic [AW-1:0] base_q, base_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] key_q, key_d;
  logic          miss_q, miss_d, hit_q, hit_d;
  logic [1:0]    done_job_q, done_job_d;
  logic          rd_done_q, rd_done_d, rd_pend_q;
  logic [AW-1:0] prev_addr_q;
`ifdef KEY_ERASE_ALL_EN
  logic [AW-1:0] hit_cnt_q, hit_cnt_d;
`endif

  logic          sw_load, sw_step, sw_last, rd_en, match, row_end;
  logic [AW-1:0] sw_start, sw_end, sw_addr, row_base;
  logic [6:0]    col_mod;

  assign row_base = AW'(row_idx) * AW'(COLS);
  assign col_mod  = new_col % 7'(COLS);
  // read data belongs to the address issued one cycle earlier
  assign match    = rd_pend_q && (ram_rdata == key_q);
  assign row_end  = rd_done_q && rd_pend_q;

  game_ram_sweep u_sweep (
    .clk     (clk),
    .reset   (reset),
    .load_i  (sw_load),
    .step_i  (sw_step),
    .start_i (sw_start),
    .end_i   (sw_end),
    .addr_o  (sw_addr),
    .last_o  (sw_last)
  );

  always_comb begin
    state_d   = state_q;
    job_d     = job_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    miss_d    = miss_q;
    hit_d     = hit_q;
    rd_done_d = rd_done_q;
`ifdef KEY_ERASE_ALL_EN
    hit_cnt_d = hit_cnt_q;
`endif
    clr_ack   = 1'b0;
    row_ack   = 1'b0;
    key_ack   = 1'b0;
    sw_load   = 1'b0;
    sw_step   = 1'b0;
    sw_start  = '0;
    sw_end    = AW'(CELLS - 1);
    rd_en     = 1'b0;
    ram_raddr = '0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    new_next  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!reset) begin
          if (clr_req) begin
            clr_ack = 1'b1;
            job_d   = JOB_CLR;
            sw_load = 1'b1;
            state_d = ST_CLR;
          end else if (row_req) begin
            row_ack = 1'b1;
            job_d   = JOB_ROW;
            miss_d  = 1'b0;
            base_d  = row_base;
            cnt_d   = row_cnt;
            if (row_idx < 5'(ROWS)) begin
              sw_load  = 1'b1;
              sw_start = row_base;
              sw_end   = row_base + AW'(COLS - 1);
              state_d  = ST_ROW_CLR;
            end else begin
              state_d = ST_FINISH;
            end
          end else if (key_req) begin
            key_ack = 1'b1;
            job_d   = JOB_KEY;
            hit_d   = 1'b0;
            key_d   = key_ascii;
`ifdef KEY_ERASE_ALL_EN
            hit_cnt_d = '0;
`endif
            if (key_ascii != '0) begin
              sw_load = 1'b1;
              state_d = ST_KEY_SCAN;
            end else begin
              state_d = ST_FINISH;
            end
          end
        end
      end
      ST_CLR: begin
        ram_wren  = 1'b1;
        ram_waddr = sw_addr;
        sw_step   = 1'b1;
        if (sw_last) state_d = ST_FINISH;
      end
      ST_ROW_CLR: begin
        rd_en = !rd_done_q;
        if (rd_pend_q) begin
          ram_wren  = 1'b1;
          ram_waddr = prev_addr_q;
          if (ram_rdata != '0) miss_d = 1'b1;
        end
        if (row_end) state_d = (cnt_q != 3'd0) ? ST_ROW_NEW : ST_FINISH;
      end
      ST_ROW_NEW: begin
        ram_wren  = 1'b1;
        ram_waddr = base_q + AW'(col_mod);
        ram_wdata = new_ascii;
        new_next  = 1'b1;
        cnt_d     = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_FINISH;
      end
      ST_KEY_SCAN: begin
        rd_en = !rd_done_q;
        if (match) begin
          ram_wren  = 1'b1;
          ram_waddr = prev_addr_q;
          hit_d     = 1'b1;
        end
`ifdef KEY_ERASE_ALL_EN
        if (match) hit_cnt_d = hit_cnt_q + AW'(1);
        if (row_end) state_d = ST_FINISH;
`else
        if (match || row_end) state_d = ST_FINISH;
`endif
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rd_en) begin
      sw_step   = 1'b1;
      ram_raddr = sw_addr;
    end
    if (sw_load) rd_done_d = 1'b0;
    else if (rd_en && sw_last) rd_done_d = 1'b1;
    done_job_d = (state_d == ST_FINISH) ? job_d : done_job_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      job_q       <= JOB_CLR;
      base_q      <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      miss_q      <= 1'b0;
      hit_q       <= 1'b0;
      done_job_q  <= '0;
      rd_done_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      prev_addr_q <= '0;
`ifdef KEY_ERASE_ALL_EN
      hit_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      miss_q      <= miss_d;
      hit_q       <= hit_d;
      done_job_q  <= done_job_d;
      rd_done_q   <= rd_done_d;
      rd_pend_q   <= rd_en;
      prev_addr_q <= sw_addr;
`ifdef KEY_ERASE_ALL_EN
      hit_cnt_q   <= hit_cnt_d;
`endif
    end
  end

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done     = (state_q == ST_FINISH);
  assign done_job = done_job_q;
  assign miss     = miss_q;
  assign hit      = hit_q;
`ifdef KEY_ERASE_ALL_EN
  assign hit_cnt  = hit_cnt_q;
`endif

endmodule

// File: tb/tb_game_ram_scheduler.sv
// Scoreboard bench: a cell-array reference model queues expected writes and dones, a monitor checks them.
module tb_game_ram_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr_req = 1'b0, row_req = 1'b0, key_req = 1'b0;
  logic [4:0] row_idx = '0;
  logic [2:0] row_cnt = '0;
  logic [6:0] new_col = '0;
  logic [7:0] new_ascii = '0;
  logic [7:0] key_ascii = '0;
  logic       new_next, clr_ack, row_ack, key_ack, busy, done, miss, hit, ram_wren;
  logic [1:0] done_job;
  logic [10:0] ram_raddr, ram_waddr;
  logic [7:0] ram_wdata, ram_rdata;
`ifdef KEY_ERASE_ALL_EN
  logic [10:0] hit_cnt;
`endif

  always #5 clk = ~clk;

  game_ram_scheduler dut (
    .clk(clk), .reset(reset),
    .clr_req(clr_req), .row_req(row_req), .row_idx(row_idx), .row_cnt(row_cnt),
    .new_col(new_col), .new_ascii(new_ascii), .new_next(new_next),
    .key_req(key_req), .key_ascii(key_ascii),
    .clr_ack(clr_ack), .row_ack(row_ack), .key_ack(key_ack),
    .busy(busy), .done(done), .done_job(done_job), .miss(miss), .hit(hit),
`ifdef KEY_ERASE_ALL_EN
    .hit_cnt(hit_cnt),
`endif
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wren(ram_wren)
  );

  // character RAM with registered read, plus a bench-side preload port
  logic [7:0]  ram [0:2047];
  logic        ram_init = 1'b1, poke_en = 1'b0;
  logic [10:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;
  always @(posedge clk) begin
    ram_rdata <= ram[ram_raddr];
    if (ram_init) begin
      for (int i = 0; i < 2048; i++) ram[i] <= 8'h00;
    end else if (ram_wren) begin
      ram[ram_waddr] <= ram_wdata;
    end else if (poke_en) begin
      ram[poke_addr] <= poke_data;
    end
  end

  typedef struct { int addr; int data; int nn; } wr_t;
  typedef struct { int job; int miss; int hit; int hcnt; } dn_t;
  typedef struct { int col; int ascii; } pl_t;
  wr_t exp_wr[$];
  dn_t exp_done[$];
  pl_t plan_q[$];
  int  ack_order[$];
  int  mdl [0:2047];
  int  m_miss = 0, m_hit = 0, m_hcnt = 0;
  int  n_tests = 0, n_fail = 0, n_wr = 0, n_done = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: cell array + job rules ----------------
  task automatic push_wr(input int a, input int d, input int nn);
    wr_t w;
    w.addr = a; w.data = d; w.nn = nn;
    exp_wr.push_back(w);
    mdl[a] = d;
  endtask

  task automatic push_done(input int job);
    dn_t x;
    x.job = job; x.miss = m_miss; x.hit = m_hit; x.hcnt = m_hcnt;
    exp_done.push_back(x);
  endtask

  task automatic model_clr();
    for (int a = 0; a < 1550; a++) push_wr(a, 0, 0);
    push_done(0);
  endtask

  task automatic model_row(input int idx, input int cnt, input bit fixed, input int fcol, input int fasc);
    m_miss = 0;
    if (idx < 31) begin
      int base = idx * 50;
      for (int c = 0; c < 50; c++) if (mdl[base + c] != 0) m_miss = 1;
      for (int c = 0; c < 50; c++) push_wr(base + c, 0, 0);
      for (int k = 0; k < cnt; k++) begin
        pl_t p;
        p.col   = fixed ? fcol : int'($urandom_range(0, 127));
        p.ascii = fixed ? fasc : int'($urandom_range(0, 255));
        plan_q.push_back(p);
        push_wr(base + (p.col % 50), p.ascii, 1);
      end
    end
    push_done(1);
  endtask

  task automatic model_key(input int k);
    m_hit = 0;
    m_hcnt = 0;
    if (k != 0) begin
      for (int a = 0; a < 1550; a++) begin
        if (mdl[a] == k) begin
`ifdef KEY_ERASE_ALL_EN
          push_wr(a, 0, 0);
          m_hcnt++;
          m_hit = 1;
`else
          if (m_hit == 0) begin
            push_wr(a, 0, 0);
            m_hit = 1;
          end
`endif
        end
      end
    end
    push_done(2);
  endtask

  // ---------------- monitor and random-source responder ----------------
  wr_t mw;
  dn_t md;
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_wren || new_next) begin
        if (ram_wren) n_wr++;
        if (exp_wr.size() == 0) chk("unexpected_write", int'(ram_waddr), -1);
        else begin
          mw = exp_wr.pop_front();
          chk("wr_addr", int'(ram_waddr), mw.addr);
          chk("wr_data", int'(ram_wdata), mw.data);
          chk("wr_en", int'(ram_wren), 1);
          chk("new_next", int'(new_next), mw.nn);
        end
      end
      if (done) begin
        n_done++;
        if (exp_done.size() == 0) chk("unexpected_done", int'(done_job), -1);
        else begin
          md = exp_done.pop_front();
          chk("done_job", int'(done_job), md.job);
          chk("done_miss", int'(miss), md.miss);
          chk("done_hit", int'(hit), md.hit);
          chk("done_busy", int'(busy), 0);
`ifdef KEY_ERASE_ALL_EN
          chk("done_hit_cnt", int'(hit_cnt), md.hcnt);
`endif
        end
      end
    end
    if (new_next && plan_q.size() != 0) void'(plan_q.pop_front());
    if (plan_q.size() != 0) begin
      new_col   = 7'(plan_q[0].col);
      new_ascii = 8'(plan_q[0].ascii);
    end else begin
      new_col   = '0;
      new_ascii = '0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit c, input bit r, input bit k);
    bit pc, pr, pk;
    int guard;
    pc = c; pr = r; pk = k; guard = 0;
    @(negedge clk); #1;
    clr_req = pc; row_req = pr; key_req = pk;
    while ((pc || pr || pk) && guard < 10000) begin
      @(negedge clk);
      guard++;
      if (clr_ack) begin ack_order.push_back(0); pc = 1'b0; end
      if (row_ack) begin ack_order.push_back(1); pr = 1'b0; end
      if (key_ack) begin ack_order.push_back(2); pk = 1'b0; end
      #1;
      clr_req = pc; row_req = pr; key_req = pk;
    end
    chk("ack_timeout", int'(pc || pr || pk), 0);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (exp_done.size() != 0 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    chk("done_timeout", exp_done.size(), 0);
    chk("writes_drained", exp_wr.size(), 0);
  endtask

  task automatic poke(input int a, input int d);
    mdl[a] = d;
    @(negedge clk); #1;
    poke_en = 1'b1; poke_addr = 11'(a); poke_data = 8'(d);
    @(negedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic do_clr();
    model_clr();
    issue(1, 0, 0);
    wait_idle();
  endtask

  task automatic do_row(input int idx, input int cnt, input bit fixed, input int fcol, input int fasc);
    row_idx = 5'(idx);
    row_cnt = 3'(cnt);
    model_row(idx, cnt, fixed, fcol, fasc);
    issue(0, 1, 0);
    wait_idle();
  endtask

  task automatic do_key(input int k);
    key_ascii = 8'(k);
    model_key(k);
    issue(0, 0, 1);
    wait_idle();
  endtask

  initial begin
    int saved, wr_before, k, a, bad, exp400, sel;
    for (int i = 0; i < 2048; i++) mdl[i] = 0;

    // reset held for three cycles
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wren", int'(ram_wren), 0);
    chk("rst_acks", int'({clr_ack, row_ack, key_ack}), 0);
    chk("rst_new_next", int'(new_next), 0);
    #1 reset = 1'b0; ram_init = 1'b0;

    do_clr();

    // reset in the middle of a clear: job abandoned, no done
    model_clr();
    issue(1, 0, 0);
    repeat (200) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_wren", int'(ram_wren), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    exp_wr.delete();
    exp_done.delete();
    m_miss = 0; m_hit = 0; m_hcnt = 0;
    saved = n_done;
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", n_done, saved);

    // row refresh over an occupied cell, same column planted twice
    poke(157, 'h41);
    do_row(3, 2, 1'b1, 57, 'h42);
    chk("row_cell157", int'(ram[157]), 'h42);
    chk("row_miss", int'(miss), 1);

    // key search with two matching cells
    poke(10, 'h4B);
    poke(400, 'h4B);
    do_key('h4B);
    exp400 = 'h4B;
`ifdef KEY_ERASE_ALL_EN
    exp400 = 0;
    chk("key_hit_cnt", int'(hit_cnt), 2);
`endif
    chk("key_cell10", int'(ram[10]), 0);
    chk("key_cell400", int'(ram[400]), exp400);
    chk("key_hit", int'(hit), 1);

    // random scatter followed by random jobs
    for (int i = 0; i < 30; i++) poke($urandom_range(0, 1549), $urandom_range(1, 255));
    for (int j = 0; j < 14; j++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        do_row($urandom_range(0, 31), $urandom_range(0, 7), 1'b0, 0, 0);
      end else if (sel < 9) begin
        k = $urandom_range(0, 255);
        if ($urandom_range(0, 1) == 1) begin
          a = $urandom_range(0, 1549);
          for (int i = 0; i < 1550; i++) begin
            if (mdl[(a + i) % 1550] != 0) begin
              k = mdl[(a + i) % 1550];
              break;
            end
          end
        end
        do_key(k);
      end else begin
        do_clr();
      end
    end

    // all three requests in the same cycle: served in priority order
    ack_order.delete();
    row_idx = 5'd10; row_cnt = 3'd3; key_ascii = 8'h55;
    model_clr();
    model_row(10, 3, 1'b1, 20, 'h55);
    model_key('h55);
    issue(1, 1, 1);
    wait_idle();
    chk("order_len", ack_order.size(), 3);
    if (ack_order.size() == 3) begin
      chk("order_first", ack_order[0], 0);
      chk("order_second", ack_order[1], 1);
      chk("order_third", ack_order[2], 2);
    end

    // null key: done without any RAM access
    wr_before = n_wr;
    do_key(0);
    chk("key0_writes", n_wr - wr_before, 0);
    chk("key0_hit", int'(hit), 0);

    bad = 0;
    for (int i = 0; i < 1550; i++) if (int'(ram[i]) != mdl[i]) bad++;
    chk("ram_final", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
